// File: rtl/pattern_event_logger_pkg.sv
// Shared defaults and entry-layout helpers for the pattern event logger.
package pattern_event_logger_pkg;

  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefTsw   = 16;

  // A FIFO entry is {timestamp, product}.
  localparam int unsigned DefEntryW = DefTsw + 2 * DefDw;

  function automatic int unsigned entry_width(input int unsigned tsw, input int unsigned dw);
    return tsw + 2 * dw;
  endfunction

endpackage

// File: rtl/pattern_event_logger_if.sv
// Valid/ready output stream carrying the FIFO head entry.
interface pattern_event_logger_if #(
  parameter int unsigned dw  = pattern_event_logger_pkg::DefDw,
  parameter int unsigned TSW = pattern_event_logger_pkg::DefTsw
);

  logic              out_valid;
  logic              out_ready;
  logic [2*dw-1:0]   out_prod;
  logic [TSW-1:0]    out_ts;

  modport master (
    output out_valid,
    output out_prod,
    output out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_prod,
    input  out_ts,
    output out_ready
  );

endinterface

// File: rtl/pattern_event_logger_event_fifo.sv
// Event FIFO: synchronous first-word-fall-through FIFO with clear and occupancy level.
// Storage is not reset; only pointers and level are.
module pattern_event_logger_event_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW-1:0] PtrOne = AddrW'(1);
  localparam logic [AddrW:0]   LvlOne = (AddrW + 1)'(1);
  localparam logic [AddrW:0]   LvlMax = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlMax);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // Next-state for pointers and level; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    do_pop  = pop_i && !empty_o && !clr_i;
    do_push = push_i && !clr_i && (!full_o || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrOne;
      if (do_pop)  rptr_d = rptr_q + PtrOne;
      if (do_push && !do_pop)      level_d = level_q + LvlOne;
      else if (!do_push && do_pop) level_d = level_q - LvlOne;
    end
  end

  // Pointer/level state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pattern_event_logger.sv
// Pattern event logger: timestamps qualified multiplier products into an FWFT FIFO and keeps
// saturating hit/drop counters plus a sticky overflow flag.
module pattern_event_logger
  import pattern_event_logger_pkg::*;
#(
  parameter int unsigned dw    = DefDw,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned TSW   = DefTsw
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [2*dw-1:0]            prod_in,
  input  logic                       hit_in,
  pattern_event_logger_if.master     out_if,
  output logic [TSW-1:0]             hit_count,
  output logic [TSW-1:0]             drop_count,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned EntryW = entry_width(TSW, dw);
  localparam logic [TSW-1:0] TsOne = TSW'(1);

  logic [TSW-1:0]    ts_q, ts_d;
  logic [TSW-1:0]    hit_count_q, hit_count_d;
  logic [TSW-1:0]    drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              push_req, pop, accept, drop;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] wdata, rdata;

  assign wdata = {ts_q, prod_in};

  pattern_event_logger_event_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_event_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .push_i  (push_req),
    .wdata_i (wdata),
    .pop_i   (out_if.out_ready),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Event qualification, drop detection and counter next-state; clr wins over same-edge traffic.
  always_comb begin
    push_req     = en && hit_in && !clr;
    pop          = out_if.out_ready && !fifo_empty && !clr;
    accept       = push_req && (!fifo_full || pop);
    drop         = push_req && fifo_full && !pop;
    ts_d         = ts_q + TsOne;
    hit_count_d  = hit_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (clr) begin
      hit_count_d  = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (accept && (hit_count_q != '1)) hit_count_d = hit_count_q + TsOne;
      if (drop && (drop_count_q != '1))  drop_count_d = drop_count_q + TsOne;
      if (drop) overflow_d = 1'b1;
    end
  end

  // Timestamp, counters and overflow flag; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q         <= '0;
      hit_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      hit_count_q  <= hit_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign hit_count        = hit_count_q;
  assign drop_count       = drop_count_q;
  assign overflow         = overflow_q;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_prod  = rdata[2*dw-1:0];
  assign out_if.out_ts    = rdata[EntryW-1 -: TSW];

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed self-checking bench for pattern_event_logger (dw=8, DEPTH=8, TSW=16).
module tb_pattern_event_logger;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, hit_in;
  logic [15:0] prod_in;
  logic [15:0] hit_count, drop_count;
  logic        overflow;
  logic [3:0]  level;
  logic [15:0] tb_ts;
  int          errors = 0;
  int          checks = 0;

  pattern_event_logger_if #(.dw(8), .TSW(16)) out_if ();

  pattern_event_logger #(.dw(8), .DEPTH(8), .TSW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .prod_in    (prod_in),
    .hit_in     (hit_in),
    .out_if     (out_if),
    .hit_count  (hit_count),
    .drop_count (drop_count),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT will capture at the next edge.
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= 16'h0;
    else        tb_ts <= tb_ts + 16'h1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; hit_in = 1'b0; clr = 1'b0; out_if.out_ready = 1'b0; prod_in = 16'h0;
  endtask

  task automatic do_clear();
    idle(); clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; hit_in = 1'b1; clr = 1'b0; out_if.out_ready = 1'b1; prod_in = 16'h77;
    tick(); tick();
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_if.out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (hit_count !== 16'h0 || drop_count !== 16'h0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_counters: got hit=%h drop=%h ovf=%b want 0/0/0", hit_count, drop_count, overflow);
    end
    idle(); rst_n = 1'b1;
  endtask

  task automatic test_single_event();
    int n = 0;
    while (tb_ts != 16'd5 && n < 20) begin tick(); n++; end
    en = 1'b1; hit_in = 1'b1; prod_in = 16'h0012;
    tick(); idle();
    checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_if.out_valid); end
    checks++; if (out_if.out_prod !== 16'h0012) begin errors++; $display("FAIL single_prod: got %h want 0012", out_if.out_prod); end
    checks++; if (out_if.out_ts !== 16'd5) begin errors++; $display("FAIL single_ts: got %h want 0005", out_if.out_ts); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL single_hits: got %0d want 1", hit_count); end
    out_if.out_ready = 1'b1; tick(); tick(); idle();  // second pop hits an empty FIFO
    checks++; if (level !== 4'd0 || out_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: got level=%0d valid=%b want 0/0", level, out_if.out_valid);
    end
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [15:0] exp_ts [10];
    logic [15:0] exp_prod [10];
    int          order [8];
    do_clear();
    for (int i = 0; i < 9; i++) begin
      en = 1'b1; hit_in = 1'b1; prod_in = 16'h0100 + 16'(i);
      exp_ts[i] = tb_ts; exp_prod[i] = prod_in;
      tick();
    end
    idle();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", level); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drops: got %0d want 1", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (hit_count !== 16'd8) begin errors++; $display("FAIL ovf_hits: got %0d want 8", hit_count); end
    // Full FIFO, event with a same-edge pop.
    en = 1'b1; hit_in = 1'b1; prod_in = 16'hABCD; out_if.out_ready = 1'b1;
    exp_ts[9] = tb_ts; exp_prod[9] = 16'hABCD;
    tick(); idle();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fullpp_level: got %0d want 8", level); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL fullpp_drops: got %0d want 1", drop_count); end
    checks++; if (hit_count !== 16'd9) begin errors++; $display("FAIL fullpp_hits: got %0d want 9", hit_count); end
    order = '{1, 2, 3, 4, 5, 6, 7, 9};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_prod !== exp_prod[order[i]] || out_if.out_ts !== exp_ts[order[i]]) begin
        errors++;
        $display("FAIL drain_%0d: got v=%b prod=%h ts=%h want 1/%h/%h", i, out_if.out_valid,
                 out_if.out_prod, out_if.out_ts, exp_prod[order[i]], exp_ts[order[i]]);
      end
      out_if.out_ready = 1'b1; tick();
    end
    idle();
    checks++; if (out_if.out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL drain_empty: got valid=%b level=%0d want 0/0", out_if.out_valid, level);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_mid_pushpop();
    do_clear();
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || hit_count !== 16'd0) begin
      errors++; $display("FAIL clr_counters: got ovf=%b drop=%0d hit=%0d want 0/0/0", overflow, drop_count, hit_count);
    end
    en = 1'b1; hit_in = 1'b1; prod_in = 16'h1111; tick();
    prod_in = 16'h2222; tick();
    prod_in = 16'h3333; out_if.out_ready = 1'b1; tick(); idle();
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL mid_level: got %0d want 2", level); end
    checks++; if (out_if.out_prod !== 16'h2222) begin errors++; $display("FAIL mid_head: got %h want 2222", out_if.out_prod); end
  endtask

  task automatic test_disabled();
    do_clear();
    en = 1'b0; hit_in = 1'b1; prod_in = 16'h5A5A;
    for (int i = 0; i < 10; i++) tick();
    idle();
    checks++; if (level !== 4'd0 || hit_count !== 16'd0) begin
      errors++; $display("FAIL disabled: got level=%0d hits=%0d want 0/0", level, hit_count);
    end
  endtask

  task automatic test_ts_wrap();
    int n = 0;
    do_clear();
    while (tb_ts != 16'hFFFF && n < 70000) begin tick(); n++; end
    checks++; if (tb_ts !== 16'hFFFF) begin errors++; $display("FAIL wrap_timeout: got %h want ffff", tb_ts); end
    en = 1'b1; hit_in = 1'b1; prod_in = 16'h0A0A; tick();
    prod_in = 16'h0B0B; tick(); idle();
    checks++; if (level !== 4'd2 || out_if.out_ts !== 16'hFFFF || out_if.out_prod !== 16'h0A0A) begin
      errors++; $display("FAIL wrap_first: got level=%0d ts=%h prod=%h want 2/ffff/0a0a", level, out_if.out_ts, out_if.out_prod);
    end
    out_if.out_ready = 1'b1; tick(); idle();
    checks++; if (out_if.out_ts !== 16'h0000 || out_if.out_prod !== 16'h0B0B) begin
      errors++; $display("FAIL wrap_second: got ts=%h prod=%h want 0000/0b0b", out_if.out_ts, out_if.out_prod);
    end
  endtask

  task automatic test_clear();
    do_clear();
    en = 1'b1; hit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin prod_in = 16'h4000 + 16'(i); tick(); end
    checks++; if (level !== 4'd3 || hit_count !== 16'd3) begin
      errors++; $display("FAIL clear_pre: got level=%0d hits=%0d want 3/3", level, hit_count);
    end
    clr = 1'b1; out_if.out_ready = 1'b1; prod_in = 16'h4444; tick(); idle();
    checks++; if (level !== 4'd0 || out_if.out_valid !== 1'b0 || hit_count !== 16'd0 ||
                  drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clear_post: got level=%0d valid=%b hit=%0d drop=%0d ovf=%b want all 0",
                         level, out_if.out_valid, hit_count, drop_count, overflow);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_clear();
    en = 1'b1; hit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin prod_in = 16'h6000 + 16'(i); tick(); end
    rst_n = 1'b0; prod_in = 16'h6666; out_if.out_ready = 1'b1; tick();
    checks++; if (level !== 4'd0 || out_if.out_valid !== 1'b0 || hit_count !== 16'd0 ||
                  drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_burst: got level=%0d valid=%b hit=%0d drop=%0d ovf=%b want all 0",
                         level, out_if.out_valid, hit_count, drop_count, overflow);
    end
    rst_n = 1'b1; out_if.out_ready = 1'b0; prod_in = 16'h0055; tick(); idle();
    checks++; if (out_if.out_ts !== 16'h0000 || out_if.out_prod !== 16'h0055 || level !== 4'd1 || hit_count !== 16'd1) begin
      errors++; $display("FAIL rst_ts: got ts=%h prod=%h level=%0d hit=%0d want 0000/0055/1/1",
                         out_if.out_ts, out_if.out_prod, level, hit_count);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single_event();
    test_overflow_and_full_pushpop();
    test_mid_pushpop();
    test_disabled();
    test_ts_wrap();
    test_clear();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
